seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Unsigned sequential restoring divider; the inverse of the 4x4 array multiplier.
//  Takes a 2W-bit dividend (a product-width value) and a W-bit divisor.
//  Returns a 2W-bit quotient and a W-bit remainder, one quotient bit per clock.
//  Sits beside the multiplier in the lab arithmetic datapath.
//  Uses a START/BUSY/DONE handshake so results can be checked against the multiplier.
// PARAMETERS
//  W  4  divisor/remainder width; dividend and quotient are 2*W bits
// PORTS
//  CLK       in   1     single clock, all state updates on rising edge
//  RST       in   1     synchronous, active-high reset
//  START     in   1     request; sampled only in IDLE or DONE state
//  DIVIDEND  in   2W    unsigned dividend, captured on accepted START
//  DIVISOR   in   W     unsigned divisor, captured on accepted START
//  Q         out  2W    quotient, registered
//  R         out  W     remainder, registered
//  BUSY      out  1     high while iterating
//  DONE      out  1     one-cycle pulse: Q/R/DZ valid
//  DZ        out  1     divide-by-zero flag, valid with DONE
// BEHAVIOUR
//  Reset: one clock; reset is synchronous and active-high.
//   - RST high at an edge forces state IDLE and clears Q, R, BUSY, DONE, DZ and internal counters to 0.
//   - Reset has priority over all other inputs, including mid-operation; an aborted divide produces no DONE.
//  States: IDLE, RUN, DONE.
//   - IDLE --START--> RUN (or DONE if DIVISOR==0).
//   - RUN --after 2W iterations--> DONE.
//   - DONE --START--> RUN/DONE; DONE --no START--> IDLE.
//  Accept: at edge k with state IDLE or DONE and START=1:
//   - capture operands, clear the partial remainder P (W+1 bits), set bit counter = 2W;
//   - BUSY=1 and DONE=0 from k.
//  START while in RUN is ignored; the captured operands are unaffected by input changes.
//  Iteration, each RUN edge, MSB of dividend first:
//   - P' = {P[W-1:0], next dividend bit};
//   - if P' >= {1'b0,divisor}: P = P' - divisor and qbit = 1; else P = P' and qbit = 0;
//   - qbit shifts into the quotient LSB; counter decrements.
//  Latency: the last iteration occurs at edge k+2W; at that edge:
//   - Q = quotient, R = P[W-1:0], DZ = 0;
//   - BUSY=0, DONE=1 for exactly one cycle.
//  Q/R/DZ hold until the next accepted START or reset.
//  Q/R are not cleared at accept; they keep the old result until the new DONE.
//  Divide by zero: START with DIVISOR==0 at edge k:
//   - at edge k+1, Q = all ones, R = 0, DZ = 1, DONE = 1;
//   - BUSY is high for that single cycle only.
//  Back-to-back: START high during the DONE cycle is accepted.
//   - The DONE pulse still lasts one cycle; BUSY rises at that same edge.
//  Invariant for non-zero divisor: DIVIDEND == Q*DIVISOR + R, with R < DIVISOR.
//  Q never overflows, because Q is 2W bits wide.
// TESTING
//  225/15 (W=4): START at edge k -> DONE at k+8, Q=15, R=0, DZ=0, BUSY high k..k+7.
//  100/7 -> Q=14, R=2; then 255/1 issued with START in the DONE cycle -> Q=255, R=0, no idle gap.
//  0/9 -> Q=0, R=0; 6/9 -> Q=0, R=6 (dividend < divisor).
//  200/0 -> DONE at k+1, Q=8'hFF, R=0, DZ=1; a following 9/3 -> Q=3, R=0, DZ=0.
//  START pulsed again mid-RUN with different operands -> ignored; first result delivered unchanged.
//  RST high at iteration 4 -> next cycle all outputs 0, state IDLE, no DONE; a new START works normally.
//  Random sweep of all 256x16 operand pairs vs the reference model (Q*D+R == dividend).

Source files
------------

// File: rtl/seq_divider_if.sv
// Operand/result bundle for the sequential divider; the slave side is the divider.
interface seq_divider_if #(
    parameter int W = 4
);
    logic             start_i;
    logic [2*W-1:0]   dividend_i;
    logic [W-1:0]     divisor_i;
    logic [2*W-1:0]   q_o;
    logic [W-1:0]     r_o;
    logic             busy_o;
    logic             done_o;
    logic             dz_o;

    modport master (
        output start_i, dividend_i, divisor_i,
        input  q_o, r_o, busy_o, done_o, dz_o
    );

    modport slave (
        input  start_i, dividend_i, divisor_i,
        output q_o, r_o, busy_o, done_o, dz_o
    );
endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider, 2W-bit dividend by W-bit divisor, one quotient bit per clock.
// DONE 2W cycles after an accepted START (1 cycle for a zero divisor); START is ignored while busy.
module seq_divider #(
    parameter int W = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    seq_divider_if.slave   bus
);
    localparam int CW = $clog2(2*W+1);
    localparam logic [CW-1:0] NBITS = CW'(2*W);
    localparam logic [CW-1:0] ONE   = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [W-1:0]    div_q;
    logic [2*W-1:0]  dvd_q;     // dividend shifts out the top while quotient bits shift in at the bottom
    logic [W:0]      p_q;
    logic [CW-1:0]   cnt_q;
    logic [2*W-1:0]  q_q;
    logic [W-1:0]    r_q;
    logic            busy_q;
    logic            done_q;
    logic            dz_q;

    logic [W:0]      p_sh_d;
    logic            take_d;
    logic [W:0]      p_d;
    logic [2*W-1:0]  dvd_d;

    always_comb begin
        p_sh_d = {p_q[W-1:0], dvd_q[2*W-1]};
        take_d = (p_sh_d >= {1'b0, div_q});
        p_d    = take_d ? (p_sh_d - {1'b0, div_q}) : p_sh_d;
        dvd_d  = {dvd_q[2*W-2:0], take_d};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            dvd_q   <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (bus.start_i) begin
                        div_q   <= bus.divisor_i;
                        dvd_q   <= bus.dividend_i;
                        p_q     <= '0;
                        cnt_q   <= NBITS;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    // A zero divisor spends its single busy cycle here and reports at once.
                    if (div_q == '0) begin
                        q_q     <= '1;
                        r_q     <= '0;
                        dz_q    <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_DONE;
                    end else begin
                        p_q   <= p_d;
                        dvd_q <= dvd_d;
                        cnt_q <= cnt_q - ONE;
                        if (cnt_q == ONE) begin
                            q_q     <= dvd_d;
                            r_q     <= p_d[W-1:0];
                            dz_q    <= 1'b0;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_DONE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.q_o    = q_q;
    assign bus.r_o    = r_q;
    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;
    assign bus.dz_o   = dz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed and exhaustive-randomized checks of seq_divider against plain / and % arithmetic.
module tb_seq_divider;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    seq_divider_if #(.W(W)) bus();

    seq_divider #(.W(W)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive START for exactly one edge; afterwards BUSY must be up and DONE down.
    task automatic issue(input logic [7:0] a, input logic [3:0] b, input string tag);
        bus.start_i    = 1'b1;
        bus.dividend_i = a;
        bus.divisor_i  = b;
        step();
        bus.start_i    = 1'b0;
        bus.dividend_i = 8'($urandom);
        bus.divisor_i  = 4'($urandom);
        chk({tag, ".busy_acc"}, 32'(bus.busy_o), 32'd1);
        chk({tag, ".done_acc"}, 32'(bus.done_o), 32'd0);
    endtask

    // Wait (bounded) for DONE and compare against the arithmetic reference.
    task automatic wait_result(input logic [7:0] a, input logic [3:0] b, input int lat0, input string tag);
        int         lat;
        bit         busy_ok;
        int         exp_lat;
        logic [7:0] eq;
        logic [3:0] er;
        logic       edz;
        lat = lat0;
        busy_ok = 1'b1;
        if (b == 4'd0) begin
            eq = 8'hFF; er = 4'd0; edz = 1'b1; exp_lat = 1;
        end else begin
            eq = a / b; er = 4'(a % b); edz = 1'b0; exp_lat = 2*W;
        end
        while (bus.done_o !== 1'b1 && lat < 40) begin
            if (bus.busy_o !== 1'b1) busy_ok = 1'b0;
            step();
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".busy_run"}, 32'(busy_ok), 32'd1);
        chk({tag, ".busy_done"}, 32'(bus.busy_o), 32'd0);
        chk({tag, ".q"}, 32'(bus.q_o), 32'(eq));
        chk({tag, ".r"}, 32'(bus.r_o), 32'(er));
        chk({tag, ".dz"}, 32'(bus.dz_o), 32'(edz));
        if (b != 4'd0) begin
            chk({tag, ".identity"}, 32'(bus.q_o) * 32'(b) + 32'(bus.r_o), 32'(a));
            chk({tag, ".r_lt_d"}, 32'(bus.r_o < b), 32'd1);
        end
    endtask

    initial begin
        logic [7:0] ra;
        logic [3:0] rb;
        logic [7:0] a;
        logic [3:0] b;

        bus.start_i    = 1'b0;
        bus.dividend_i = '0;
        bus.divisor_i  = '0;
        rst = 1'b1;
        step();
        step();
        chk("rst.q", 32'(bus.q_o), 32'd0);
        chk("rst.r", 32'(bus.r_o), 32'd0);
        chk("rst.busy", 32'(bus.busy_o), 32'd0);
        chk("rst.done", 32'(bus.done_o), 32'd0);
        chk("rst.dz", 32'(bus.dz_o), 32'd0);
        rst = 1'b0;
        step();

        issue(8'd225, 4'd15, "d225_15");
        wait_result(8'd225, 4'd15, 0, "d225_15");
        step();
        chk("d225_15.done_pulse", 32'(bus.done_o), 32'd0);
        chk("d225_15.hold_q", 32'(bus.q_o), 32'd15);

        // 255/1 accepted in the DONE cycle of 100/7; old result stays visible until the new DONE.
        issue(8'd100, 4'd7, "d100_7");
        wait_result(8'd100, 4'd7, 0, "d100_7");
        issue(8'd255, 4'd1, "b2b_255_1");
        chk("b2b.q_held", 32'(bus.q_o), 32'd14);
        chk("b2b.r_held", 32'(bus.r_o), 32'd2);
        wait_result(8'd255, 4'd1, 0, "b2b_255_1");

        issue(8'd0, 4'd9, "d0_9");
        wait_result(8'd0, 4'd9, 0, "d0_9");
        issue(8'd6, 4'd9, "d6_9");
        wait_result(8'd6, 4'd9, 0, "d6_9");

        issue(8'd200, 4'd0, "dz200");
        wait_result(8'd200, 4'd0, 0, "dz200");
        issue(8'd9, 4'd3, "d9_3");
        wait_result(8'd9, 4'd3, 0, "d9_3");
        step();

        // A second START mid-run must not disturb the operation in flight.
        issue(8'd77, 4'd5, "midrun");
        step(); step(); step();
        bus.start_i = 1'b1; bus.dividend_i = 8'd250; bus.divisor_i = 4'd3;
        step();
        bus.start_i = 1'b0;
        wait_result(8'd77, 4'd5, 4, "midrun");
        step();

        // Reset at the fourth iteration edge aborts with no DONE.
        issue(8'd123, 4'd4, "abort");
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort.q", 32'(bus.q_o), 32'd0);
        chk("abort.r", 32'(bus.r_o), 32'd0);
        chk("abort.busy", 32'(bus.busy_o), 32'd0);
        chk("abort.done", 32'(bus.done_o), 32'd0);
        chk("abort.dz", 32'(bus.dz_o), 32'd0);
        begin
            bit saw_done;
            saw_done = 1'b0;
            for (int i = 0; i < 10; i++) begin
                step();
                if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) saw_done = 1'b1;
            end
            chk("abort.quiet", 32'(saw_done), 32'd0);
        end
        issue(8'd123, 4'd4, "after_abort");
        wait_result(8'd123, 4'd4, 0, "after_abort");

        // Every operand pair once, in a scrambled order, with random idle gaps.
        ra = 8'($urandom);
        rb = 4'($urandom);
        for (int idx = 0; idx < 4096; idx++) begin
            a = 8'(idx) ^ ra;
            b = 4'(idx >> 8) ^ rb;
            if ($urandom_range(1, 0) == 0) step();
            issue(a, b, "sweep");
            wait_result(a, b, 0, "sweep");
        end
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
